// File: rtl/kgp_ctrl_pkg.sv
// kgp_ctrl_pkg: shared constants and types for the KGPMini control sequencer.
// Opcodes, ALU codes, instruction field positions, FSM state and the
// instruction class produced by the decoder.
package kgp_ctrl_pkg;

  // Opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_LD   = 6'h01;
  localparam logic [5:0] OP_ST   = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h03;
  localparam logic [5:0] OP_BR   = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h3F;

  // ALU operation codes driven on ALUc
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;

  // Instruction field bit positions
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int FUNC_HI = 4;
  localparam int FUNC_LO = 0;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  // Instruction classes resolved from the opcode
  typedef enum logic [2:0] {
    C_ALU,
    C_LD,
    C_ST,
    C_BEQ,
    C_BR,
    C_HALT,
    C_ILL
  } iclass_t;

endpackage

// File: rtl/kgp_instr_decode.sv
// kgp_instr_decode: purely combinational instruction decoder.
// Splits the instruction register into register selects, ALU code,
// instruction class and a sign-extended immediate truncated to PC_W bits.
module kgp_instr_decode
  import kgp_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic [31:0]     ir,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      alu_code,
  output logic [2:0]      iclass,
  output logic [PC_W-1:0] imm_ext
);

  assign rs = ir[RS_HI:RS_LO];
  assign rt = ir[RT_HI:RT_LO];

  // Sign-extend the 16-bit immediate bit by bit; bits above 15 copy the sign.
  for (genvar gi = 0; gi < PC_W; gi++) begin : g_imm
    if (gi <= IMM_HI) begin : g_low
      assign imm_ext[gi] = ir[IMM_LO + gi];
    end else begin : g_sign
      assign imm_ext[gi] = ir[IMM_HI];
    end
  end

  // Opcode to class and ALU operation; unknown opcodes fall into C_ILL.
  always_comb begin
    alu_code = ALU_ADD;
    iclass   = C_ILL;
    case (ir[OP_HI:OP_LO])
      OP_ALU: begin
        iclass   = C_ALU;
        alu_code = ir[FUNC_HI:FUNC_LO];
      end
      OP_LD:   iclass = C_LD;
      OP_ST:   iclass = C_ST;
      OP_BEQ: begin
        iclass   = C_BEQ;
        alu_code = ALU_SUB;
      end
      OP_BR:   iclass = C_BR;
      OP_HALT: iclass = C_HALT;
      default: iclass = C_ILL;
    endcase
  end

endmodule

// File: rtl/kgp_ctrl_seq.sv
// kgp_ctrl_seq: multi-cycle control sequencer for the KGPMini datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. Every output is a
// register loaded from the next-state decode, so strobes line up with states.
// Optional feature macro: KGP_CTRL_ICOUNT_EN enables the retired-instruction
// counter; without it instr_count is tied to zero.
module kgp_ctrl_seq
  import kgp_ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic [2:0]      flags,
  output logic [4:0]      r1,
  output logic [4:0]      r2,
  output logic [4:0]      ALUc,
  output logic            regw,
  output logic            memw,
  output logic            memr,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [31:0]     instr_count
);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [31:0]     ir_reg;
  logic [4:0]      r1_reg, r2_reg, aluc_reg;
  logic            imem_req_reg, regw_reg, memw_reg, memr_reg;
  logic            busy_reg, halted_reg, illegal_reg;
  logic            retire;

  logic [4:0]      dec_rs, dec_rt, dec_alu;
  logic [2:0]      dec_class;
  logic [PC_W-1:0] dec_imm;

  // Only the zero flag steers branches; the others are not consumed here.
  logic            flags_unused;
  assign flags_unused = ^flags[2:1];

  kgp_instr_decode #(.PC_W(PC_W)) u_decode (
    .ir       (ir_reg),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .alu_code (dec_alu),
    .iclass   (dec_class),
    .imm_ext  (dec_imm)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, next-PC and retirement decode.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    retire     = 1'b0;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH:  if (imem_ack) state_next = S_DECODE;
      S_DECODE: begin
        if (dec_class == C_HALT || dec_class == C_ILL) state_next = S_HALT;
        else                                           state_next = S_EXEC;
      end
      S_EXEC: begin
        case (dec_class)
          C_ALU:       state_next = S_WB;
          C_LD, C_ST:  state_next = S_MEM;
          C_BEQ: begin
            state_next = S_FETCH;
            pc_next    = flags[0] ? pc_reg + dec_imm : pc_reg + PC_W'(1);
            retire     = 1'b1;
          end
          C_BR: begin
            state_next = S_FETCH;
            pc_next    = pc_reg + dec_imm;
            retire     = 1'b1;
          end
          default:     state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        if (dec_class == C_LD) begin
          state_next = S_WB;
        end else begin
          state_next = S_FETCH;
          pc_next    = pc_reg + PC_W'(1);
          retire     = 1'b1;
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        pc_next    = pc_reg + PC_W'(1);
        retire     = 1'b1;
      end
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_IDLE;
    endcase
  end

  // PC, instruction register and operand selects held from DECODE onward.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg   <= '0;
      ir_reg   <= '0;
      r1_reg   <= '0;
      r2_reg   <= '0;
      aluc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (state_reg == S_FETCH && imem_ack) ir_reg <= imem_rdata;
      if (state_reg == S_DECODE) begin
        r1_reg   <= dec_rs;
        r2_reg   <= dec_rt;
        aluc_reg <= dec_alu;
      end
    end
  end

  // Registered strobes and status, decoded from the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_req_reg <= 1'b0;
      regw_reg     <= 1'b0;
      memw_reg     <= 1'b0;
      memr_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      halted_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
    end else begin
      imem_req_reg <= (state_next == S_FETCH);
      regw_reg     <= (state_next == S_WB);
      memw_reg     <= (state_next == S_MEM) && (dec_class == C_ST);
      memr_reg     <= ((state_next == S_MEM) || (state_next == S_WB)) && (dec_class == C_LD);
      busy_reg     <= (state_next != S_IDLE) && (state_next != S_HALT);
      if (state_next == S_HALT) halted_reg <= 1'b1;
      if (state_reg == S_DECODE && dec_class == C_ILL) illegal_reg <= 1'b1;
    end
  end

`ifdef KGP_CTRL_ICOUNT_EN
  logic [31:0] icount_reg;

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      icount_reg <= '0;
    else if (retire) icount_reg <= icount_reg + 32'd1;
  end

  assign instr_count = icount_reg;
`else
  logic retire_unused;
  assign retire_unused = retire;
  assign instr_count   = '0;
`endif

  assign imem_req  = imem_req_reg;
  assign imem_addr = pc_reg;
  assign r1        = r1_reg;
  assign r2        = r2_reg;
  assign ALUc      = aluc_reg;
  assign regw      = regw_reg;
  assign memw      = memw_reg;
  assign memr      = memr_reg;
  assign busy      = busy_reg;
  assign halted    = halted_reg;
  assign illegal   = illegal_reg;

endmodule

// File: tb/tb_kgp_ctrl_seq.sv
// tb_kgp_ctrl_seq: directed self-checking bench for kgp_ctrl_seq.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_kgp_ctrl_seq;

`ifdef KGP_CTRL_ICOUNT_EN
  localparam bit ICNT = 1'b1;
`else
  localparam bit ICNT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [2:0]  flags;
  logic [4:0]  r1, r2, ALUc;
  logic        regw, memw, memr, busy, halted, illegal;
  logic [31:0] instr_count;

  int total = 0;
  int bad   = 0;

  kgp_ctrl_seq #(.PC_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .flags       (flags),
    .r1          (r1),
    .r2          (r2),
    .ALUc        (ALUc),
    .regw        (regw),
    .memw        (memw),
    .memr        (memr),
    .busy        (busy),
    .halted      (halted),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = '0; flags = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Pulse start; returns in the first FETCH cycle.
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Ack an instruction in the current FETCH cycle; returns in DECODE.
  task automatic fetch(input logic [31:0] instr);
    imem_ack = 1'b1; imem_rdata = instr;
    step();
    imem_ack = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    reset = 1'b0;
    #1;
    chk("rst_busy",   {31'd0, busy},     32'd0);
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_addr",   {24'd0, imem_addr}, 32'd0);
    chk("rst_sel",    {17'd0, r1, r2, ALUc}, 32'd0);
    chk("rst_strobe", {29'd0, regw, memw, memr}, 32'd0);
    chk("rst_status", {30'd0, halted, illegal}, 32'd0);
    chk("rst_icnt",   instr_count, 32'd0);

    // R-type: func 3, rs 1, rt 2
    do_reset();
    launch();
    chk("alu_c1_req",  {31'd0, imem_req}, 32'd1);
    chk("alu_c1_busy", {31'd0, busy},     32'd1);
    fetch(32'h0022_1003);
    chk("alu_c2_regw", {31'd0, regw}, 32'd0);
    step();
    chk("alu_c3_r1",   {27'd0, r1},   32'd1);
    chk("alu_c3_r2",   {27'd0, r2},   32'd2);
    chk("alu_c3_aluc", {27'd0, ALUc}, 32'd3);
    chk("alu_c3_regw", {31'd0, regw}, 32'd0);
    step();
    chk("alu_c4_regw", {31'd0, regw}, 32'd1);
    chk("alu_c4_mem",  {30'd0, memw, memr}, 32'd0);
    step();
    chk("alu_c5_regw", {31'd0, regw},      32'd0);
    chk("alu_pc",      {24'd0, imem_addr}, 32'd1);
    chk("alu_req",     {31'd0, imem_req},  32'd1);
    chk("alu_icnt",    instr_count, ICNT ? 32'd1 : 32'd0);

    // LD: rs 2, rt 3
    do_reset();
    launch();
    fetch(32'h0443_0000);
    chk("ld_c2_memr", {31'd0, memr}, 32'd0);
    step();
    chk("ld_c3_sel",  {17'd0, r1, r2, ALUc}, {17'd0, 5'd2, 5'd3, 5'd0});
    chk("ld_c3_memr", {31'd0, memr}, 32'd0);
    step();
    chk("ld_c4_strb", {29'd0, regw, memw, memr}, 32'b001);
    step();
    chk("ld_c5_strb", {29'd0, regw, memw, memr}, 32'b101);
    step();
    chk("ld_c6_strb", {29'd0, regw, memw, memr}, 32'b000);
    chk("ld_pc",      {24'd0, imem_addr}, 32'd1);

    // BEQ imm -1, taken: PC wraps to 0xFF
    do_reset();
    launch();
    fetch(32'h0C00_FFFF);
    step();
    flags = 3'b001;
    chk("beq_aluc", {27'd0, ALUc}, 32'd1);
    step();
    flags = 3'b000;
    chk("beq_t_pc",  {24'd0, imem_addr}, 32'hFF);
    chk("beq_t_req", {31'd0, imem_req},  32'd1);
    chk("beq_icnt",  instr_count, ICNT ? 32'd1 : 32'd0);

    // BEQ not taken: zero flag only present before EXEC
    do_reset();
    launch();
    fetch(32'h0C00_FFFF);
    flags = 3'b001;
    step();
    flags = 3'b000;
    step();
    chk("beq_n_pc", {24'd0, imem_addr}, 32'd1);

    // BR +5
    do_reset();
    launch();
    fetch(32'h1000_0005);
    step();
    step();
    chk("br_pc", {24'd0, imem_addr}, 32'd5);

    // Fetch stall: ack withheld for 3 cycles
    do_reset();
    launch();
    for (int i = 0; i < 3; i++) begin
      chk("stall_req",    {31'd0, imem_req},  32'd1);
      chk("stall_addr",   {24'd0, imem_addr}, 32'd0);
      chk("stall_strobe", {29'd0, regw, memw, memr}, 32'd0);
      step();
    end
    chk("stall_req4", {31'd0, imem_req}, 32'd1);
    fetch(32'h0022_1003);
    chk("stall_dec_req", {31'd0, imem_req}, 32'd0);
    chk("stall_dec_strb", {29'd0, regw, memw, memr}, 32'd0);

    // Illegal opcode 0x2A
    do_reset();
    launch();
    fetch(32'hA800_0000);
    step();
    chk("ill_status", {29'd0, illegal, halted, busy}, 32'b110);
    chk("ill_pc",     {24'd0, imem_addr}, 32'd0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("ill_start_busy", {30'd0, busy, imem_req}, 32'd0);
    chk("ill_start_stat", {30'd0, illegal, halted}, 32'b11);

    // HALT opcode: halted without illegal
    do_reset();
    launch();
    fetch(32'hFC00_0000);
    step();
    chk("halt_status", {29'd0, illegal, halted, busy}, 32'b010);
    chk("halt_icnt",   instr_count, 32'd0);

    // ST completes, then reset during MEM of a second ST
    do_reset();
    launch();
    fetch(32'h0800_0000);
    step();
    chk("st_c3_memw", {31'd0, memw}, 32'd0);
    step();
    chk("st_c4_strb", {29'd0, regw, memw, memr}, 32'b010);
    step();
    chk("st_pc",      {24'd0, imem_addr}, 32'd1);
    chk("st_c5_memw", {31'd0, memw}, 32'd0);
    fetch(32'h0800_0000);
    step();
    step();
    chk("st2_memw",   {31'd0, memw}, 32'd1);
    chk("st2_icnt",   instr_count, ICNT ? 32'd1 : 32'd0);
    reset = 1'b0;
    #1;
    chk("rmid_memw",  {31'd0, memw}, 32'd0);
    chk("rmid_idle",  {30'd0, busy, imem_req}, 32'd0);
    chk("rmid_pc",    {24'd0, imem_addr}, 32'd0);
    chk("rmid_icnt",  instr_count, 32'd0);
    reset = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
